// File: rtl/gamma_lut_mc.sv
// Multi-channel gamma/transfer-curve LUT for the video output path.
// One shared synchronous RAM read port is time-multiplexed across the CH
// components of each pixel; output lags input by exactly one ce_pix.
module gamma_lut_mc #(
    parameter int unsigned DW = 8,
    parameter int unsigned CH = 3,
    parameter int unsigned SW = 4,
    parameter int unsigned CW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk_vid,
    input  logic               reset_n,
    input  logic               ce_pix,
    input  logic               gamma_en,
    input  logic               shared,
    input  logic               lut_wr,
    input  logic [CW+DW-1:0]   lut_addr,
    input  logic [DW-1:0]      lut_data,
    input  logic [SW-1:0]      sb_in,
    input  logic [CH*DW-1:0]   rgb_in,
    output logic [SW-1:0]      sb_out,
    output logic [CH*DW-1:0]   rgb_out,
    output logic               busy,
    output logic               overrun,
    input  logic               overrun_clr
);

    localparam int unsigned PW    = CH * DW;
    localparam int unsigned AW    = CW + DW;
    localparam int unsigned DEPTH = CH * (2 ** DW);
    localparam int unsigned IW    = $clog2(CH + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOOKUP = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;

    // Latched pixel k (being looked up) and its per-pixel controls
    logic [PW-1:0]   pix_q;
    logic [SW-1:0]   sb_q;
    logic            gam_q;
    logic            shr_q;

    logic [PW-1:0]   res_q;
    logic [PW-1:0]   rgb_out_q;
    logic [SW-1:0]   sb_out_q;
    logic            overrun_q;

    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   rd_data_q;

    logic            rd_en_c;
    logic [AW-1:0]   rd_addr_c;
    logic            cap_en_c;
    logic            ovr_set_c;
    logic [CW-1:0]   seq_chan_c;
    logic [DW-1:0]   seq_pix_c;
    logic            wr_ok_c;

    // Writes to a channel field outside 0..CH-1 are silently dropped
    assign wr_ok_c = ({1'b0, lut_addr[AW-1:DW]} < (CW+1)'(CH));

    // Table write port and synchronous read port (read-before-write)
    always_ff @(posedge clk_vid) begin
        if (lut_wr && wr_ok_c) begin
            mem[lut_addr] <= lut_data;
        end
        if (rd_en_c) begin
            rd_data_q <= mem[rd_addr_c];
        end
    end

    // Channel/component picked for the sequencer's current step
    always_comb begin
        seq_chan_c = '0;
        seq_pix_c  = pix_q[PW-1 -: DW];
        for (int unsigned c = 1; c < CH; c++) begin
            if (idx_q == IW'(c)) begin
                seq_chan_c = shr_q ? '0 : CW'(c);
                seq_pix_c  = pix_q[(CH-1-c)*DW +: DW];
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Sequencer next-state, RAM read issue and result capture strobes
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_en_c   = 1'b0;
        rd_addr_c = '0;
        cap_en_c  = 1'b0;
        ovr_set_c = 1'b0;
        if (ce_pix) begin
            // Channel 0 reads straight from the port; its channel field is 0
            // in both shared and per-channel modes.
            ovr_set_c = (state_q == S_LOOKUP);
            rd_en_c   = 1'b1;
            rd_addr_c = {CW'(0), rgb_in[PW-1 -: DW]};
            state_d   = S_LOOKUP;
            idx_d     = IW'(1);
        end else if (state_q == S_LOOKUP) begin
            cap_en_c = 1'b1;
            if (idx_q >= IW'(CH)) begin
                state_d = S_IDLE;
                idx_d   = '0;
            end else begin
                rd_en_c   = 1'b1;
                rd_addr_c = {seq_chan_c, seq_pix_c};
                idx_d     = idx_q + IW'(1);
            end
        end
    end

    // Pixel pipeline, result capture and sticky overrun flag
    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            pix_q     <= '0;
            sb_q      <= '0;
            gam_q     <= 1'b0;
            shr_q     <= 1'b0;
            res_q     <= '0;
            rgb_out_q <= '0;
            sb_out_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (ce_pix) begin
                rgb_out_q <= gam_q ? res_q : pix_q;
                sb_out_q  <= sb_q;
                pix_q     <= rgb_in;
                sb_q      <= sb_in;
                gam_q     <= gamma_en;
                shr_q     <= shared;
            end
            if (cap_en_c) begin
                for (int unsigned c = 0; c < CH; c++) begin
                    if (idx_q == IW'(c + 1)) begin
                        res_q[(CH-1-c)*DW +: DW] <= rd_data_q;
                    end
                end
            end
            overrun_q <= ovr_set_c | (overrun_q & ~overrun_clr);
        end
    end

    assign rgb_out = rgb_out_q;
    assign sb_out  = sb_out_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == S_LOOKUP);

endmodule

// File: tb/tb_gamma_lut_mc.sv
// Directed bench for gamma_lut_mc (DW=8, CH=3, SW=4).
module tb_gamma_lut_mc;

    localparam int DW = 8;
    localparam int CH = 3;
    localparam int SW = 4;
    localparam int CW = 2;

    logic              clk_vid = 1'b0;
    logic              reset_n = 1'b0;
    logic              ce_pix = 1'b0;
    logic              gamma_en = 1'b0;
    logic              shared = 1'b0;
    logic              lut_wr = 1'b0;
    logic [CW+DW-1:0]  lut_addr = '0;
    logic [DW-1:0]     lut_data = '0;
    logic [SW-1:0]     sb_in = '0;
    logic [CH*DW-1:0]  rgb_in = '0;
    logic              overrun_clr = 1'b0;
    logic [SW-1:0]     sb_out;
    logic [CH*DW-1:0]  rgb_out;
    logic              busy;
    logic              overrun;

    int tests = 0;
    int fails = 0;

    gamma_lut_mc #(.DW(DW), .CH(CH), .SW(SW), .CW(CW)) dut (
        .clk_vid     (clk_vid),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .gamma_en    (gamma_en),
        .shared      (shared),
        .lut_wr      (lut_wr),
        .lut_addr    (lut_addr),
        .lut_data    (lut_data),
        .sb_in       (sb_in),
        .rgb_in      (rgb_in),
        .sb_out      (sb_out),
        .rgb_out     (rgb_out),
        .busy        (busy),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0 identity, 1 invert, 2 half
    task automatic load(input int ch, input int mode);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk_vid);
            lut_wr   = 1'b1;
            lut_addr = {ch[1:0], i[7:0]};
            if (mode == 0)      lut_data = i[7:0];
            else if (mode == 1) lut_data = 8'(255 - i);
            else                lut_data = 8'(i >> 1);
        end
        @(negedge clk_vid);
        lut_wr = 1'b0;
    endtask

    // One ce_pix pulse then three idle cycles (1-in-4 cadence)
    task automatic send(input logic [23:0] p, input logic [3:0] sb, input logic g, input logic s);
        @(negedge clk_vid);
        ce_pix   = 1'b1;
        rgb_in   = p;
        sb_in    = sb;
        gamma_en = g;
        shared   = s;
        @(negedge clk_vid);
        ce_pix = 1'b0;
        repeat (3) @(negedge clk_vid);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_vid);
        chk("rst_rgb", 32'(rgb_out), 32'h0);
        chk("rst_sb", 32'(sb_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk_vid);
        reset_n = 1'b1;

        // Identity tables, plus busy window t+1..t+3
        load(0, 0); load(1, 0); load(2, 0);
        @(negedge clk_vid);
        ce_pix = 1'b1; rgb_in = 24'h123456; sb_in = 4'h5; gamma_en = 1'b1; shared = 1'b0;
        @(negedge clk_vid);
        ce_pix = 1'b0;
        chk("busy_t1", 32'(busy), 32'h1);
        repeat (2) @(negedge clk_vid);
        chk("busy_t3", 32'(busy), 32'h1);
        @(negedge clk_vid);
        chk("busy_t4", 32'(busy), 32'h0);
        send(24'hABCDEF, 4'hA, 1'b1, 1'b0);
        chk("ident_rgb", 32'(rgb_out), 32'h123456);
        chk("ident_sb", 32'(sb_out), 32'h5);
        send(24'h000000, 4'h0, 1'b1, 1'b0);
        chk("ident_rgb2", 32'(rgb_out), 32'hABCDEF);
        chk("ident_sb2", 32'(sb_out), 32'hA);

        // Invert tables, corrected then bypass
        load(0, 1); load(1, 1); load(2, 1);
        send(24'h00FF80, 4'h3, 1'b1, 1'b0);
        send(24'h00FF80, 4'h6, 1'b0, 1'b0);
        chk("inv_rgb", 32'(rgb_out), 32'hFF007F);
        chk("inv_sb", 32'(sb_out), 32'h3);
        send(24'h000000, 4'h0, 1'b1, 1'b0);
        chk("bypass_rgb", 32'(rgb_out), 32'h00FF80);
        chk("bypass_sb", 32'(sb_out), 32'h6);

        // Half curve on table 0, identity on 1/2; shared vs per-channel
        load(0, 2); load(1, 0); load(2, 0);
        send(24'h804020, 4'h0, 1'b1, 1'b1);
        send(24'h804020, 4'h0, 1'b1, 1'b0);
        chk("shared_rgb", 32'(rgb_out), 32'h402010);
        send(24'h000000, 4'h0, 1'b1, 1'b0);
        chk("perch_rgb", 32'(rgb_out), 32'h404020);

        // Write to channel 3 must be dropped
        @(negedge clk_vid);
        lut_wr = 1'b1; lut_addr = 10'h305; lut_data = 8'hAA;
        @(negedge clk_vid);
        lut_wr = 1'b0;
        send(24'h050505, 4'h0, 1'b1, 1'b0);
        send(24'h000000, 4'h0, 1'b1, 1'b0);
        chk("drop_wr", 32'(rgb_out), 32'h020505);

        // Overrun: 2-cycle spacing sets, stays set, clear works
        chk("ovr_idle", 32'(overrun), 32'h0);
        @(negedge clk_vid); ce_pix = 1'b1; rgb_in = 24'h010203;
        @(negedge clk_vid); ce_pix = 1'b0;
        @(negedge clk_vid); ce_pix = 1'b1;
        @(negedge clk_vid); ce_pix = 1'b0;
        chk("ovr_set", 32'(overrun), 32'h1);
        repeat (6) @(negedge clk_vid);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        @(negedge clk_vid);
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);
        repeat (4) send(24'h111111, 4'h1, 1'b1, 1'b0);
        chk("ovr_4cyc", 32'(overrun), 32'h0);

        // Set wins over a simultaneous clear
        @(negedge clk_vid); ce_pix = 1'b1;
        @(negedge clk_vid); ce_pix = 1'b0;
        @(negedge clk_vid); ce_pix = 1'b1;
        @(negedge clk_vid); overrun_clr = 1'b1;
        @(negedge clk_vid); ce_pix = 1'b0; overrun_clr = 1'b0;
        chk("ovr_set_wins", 32'(overrun), 32'h1);
        overrun_clr = 1'b1;
        @(negedge clk_vid);
        overrun_clr = 1'b0;
        repeat (4) @(negedge clk_vid);
        chk("ovr_clr2", 32'(overrun), 32'h0);

        // Reset mid-sequence at t+2 of an overrunning pixel
        send(24'h123456, 4'h2, 1'b1, 1'b0);
        send(24'h804020, 4'h7, 1'b1, 1'b0);
        @(negedge clk_vid); ce_pix = 1'b1; rgb_in = 24'h111111; sb_in = 4'h7;
        @(negedge clk_vid); ce_pix = 1'b0;
        @(negedge clk_vid); ce_pix = 1'b1; rgb_in = 24'h222222; sb_in = 4'h3;
        @(negedge clk_vid); ce_pix = 1'b0;
        @(negedge clk_vid);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_ovr", 32'(overrun), 32'h1);
        chk("pre_rst_nz", 32'(rgb_out != '0), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
        chk("mid_rst_sb", 32'(sb_out), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_ovr", 32'(overrun), 32'h0);
        @(negedge clk_vid);
        reset_n = 1'b1;
        send(24'h804020, 4'h9, 1'b1, 1'b0);
        chk("post_rst_first", 32'(rgb_out), 32'h0);
        chk("post_rst_sb0", 32'(sb_out), 32'h0);
        send(24'h000000, 4'h0, 1'b1, 1'b0);
        chk("post_rst_map", 32'(rgb_out), 32'h404020);
        chk("post_rst_sb", 32'(sb_out), 32'h9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
